// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BTB plus gshare PHT of 2-bit counters,
// with a speculative global history and recovery from resolved mispredicts.
module branch_predict_unit #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int GHR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      regF_i_pc,
  input  logic             ctrl_i_regF_stall,
  output logic             predict_o_taken,
  output logic [31:0]      predict_o_target,
  output logic             predict_o_hit,
  output logic [GHR_W-1:0] predict_o_ghr,
  input  logic             execute_i_valid,
  input  logic [31:0]      execute_i_pc,
  input  logic             execute_i_is_branch,
  input  logic             execute_i_taken,
  input  logic [31:0]      execute_i_target,
  input  logic [GHR_W-1:0] execute_i_ghr,
  input  logic             execute_i_mispredict,
  output logic [31:0]      stat_o_branches,
  output logic [31:0]      stat_o_mispredicts
);
  localparam int unsigned N = 1 << IDX_W;

  logic             r_btb_valid  [N];
  logic [TAG_W-1:0] r_btb_tag    [N];
  logic [31:0]      r_btb_target [N];
  logic             r_btb_jump   [N];
  logic [1:0]       r_pht        [N];
  logic [GHR_W-1:0] r_ghr;
  logic [31:0]      r_stat_br;
  logic [31:0]      r_stat_mp;

  logic [IDX_W-1:0] w_f_idx, w_f_pht_idx, w_e_idx, w_e_pht_idx;
  logic [TAG_W-1:0] w_f_tag, w_e_tag;
  logic             w_hit, w_taken;
  logic [GHR_W:0]   w_spec_shift, w_rec_shift;
  logic [GHR_W-1:0] w_ghr_next;
  logic [1:0]       w_ctr_cur, w_ctr_next;
  logic             w_unused;

  assign w_f_idx     = regF_i_pc[IDX_W+1:2];
  assign w_f_tag     = regF_i_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_f_pht_idx = w_f_idx ^ IDX_W'(r_ghr);
  assign w_e_idx     = execute_i_pc[IDX_W+1:2];
  assign w_e_tag     = execute_i_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_e_pht_idx = w_e_idx ^ IDX_W'(execute_i_ghr);

  always_comb begin
    w_hit   = r_btb_valid[w_f_idx] && (r_btb_tag[w_f_idx] == w_f_tag);
    w_taken = w_hit && (r_btb_jump[w_f_idx] || r_pht[w_f_pht_idx][1]);
  end

  assign predict_o_hit      = w_hit;
  assign predict_o_taken    = w_taken;
  assign predict_o_target   = w_hit ? r_btb_target[w_f_idx] : '0;
  assign predict_o_ghr      = r_ghr;
  assign stat_o_branches    = r_stat_br;
  assign stat_o_mispredicts = r_stat_mp;

  // Shift through a GHR_W+1 wide vector so GHR_W=1 needs no special case.
  assign w_spec_shift = {r_ghr, w_taken};
  assign w_rec_shift  = {execute_i_ghr, execute_i_taken};

  always_comb begin
    w_ghr_next = r_ghr;
    if (execute_i_valid && execute_i_mispredict)
      w_ghr_next = execute_i_is_branch ? w_rec_shift[GHR_W-1:0] : execute_i_ghr;
    else if (!ctrl_i_regF_stall && w_hit && !r_btb_jump[w_f_idx])
      w_ghr_next = w_spec_shift[GHR_W-1:0];
  end

  always_comb begin
    w_ctr_cur  = r_pht[w_e_pht_idx];
    w_ctr_next = w_ctr_cur;
    if (execute_i_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btb_valid <= '{default: 1'b0};
      r_pht       <= '{default: 2'b01};
      r_ghr       <= '0;
      r_stat_br   <= '0;
      r_stat_mp   <= '0;
    end else begin
      r_ghr <= w_ghr_next;
      if (execute_i_valid) begin
        r_stat_br <= r_stat_br + 32'd1;
        if (execute_i_mispredict) r_stat_mp <= r_stat_mp + 32'd1;
        if (execute_i_is_branch) r_pht[w_e_pht_idx] <= w_ctr_next;
        if (execute_i_taken) begin
          r_btb_valid[w_e_idx]  <= 1'b1;
          r_btb_tag[w_e_idx]    <= w_e_tag;
          r_btb_target[w_e_idx] <= execute_i_target;
          r_btb_jump[w_e_idx]   <= !execute_i_is_branch;
        end
      end
    end
  end

  assign w_unused = ^{regF_i_pc[31:IDX_W+TAG_W+2], regF_i_pc[1:0],
                      execute_i_pc[31:IDX_W+TAG_W+2], execute_i_pc[1:0],
                      w_spec_shift[GHR_W], w_rec_shift[GHR_W]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and randomized checks of branch_predict_unit against a table-level
// model of the BTB, PHT counters, global history and statistics.
module tb_branch_predict_unit;
  localparam int IDX_W = 6;
  localparam int TAG_W = 8;
  localparam int GHR_W = 6;
  localparam int N = 1 << IDX_W;
  localparam int G = 1 << GHR_W;
  localparam int T = 1 << TAG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      regF_i_pc;
  logic             ctrl_i_regF_stall;
  logic             predict_o_taken;
  logic [31:0]      predict_o_target;
  logic             predict_o_hit;
  logic [GHR_W-1:0] predict_o_ghr;
  logic             execute_i_valid;
  logic [31:0]      execute_i_pc;
  logic             execute_i_is_branch;
  logic             execute_i_taken;
  logic [31:0]      execute_i_target;
  logic [GHR_W-1:0] execute_i_ghr;
  logic             execute_i_mispredict;
  logic [31:0]      stat_o_branches;
  logic [31:0]      stat_o_mispredicts;

  always #5 clk = ~clk;

  branch_predict_unit #(.IDX_W(IDX_W), .TAG_W(TAG_W), .GHR_W(GHR_W)) dut (
    .clk(clk), .rst(rst),
    .regF_i_pc(regF_i_pc), .ctrl_i_regF_stall(ctrl_i_regF_stall),
    .predict_o_taken(predict_o_taken), .predict_o_target(predict_o_target),
    .predict_o_hit(predict_o_hit), .predict_o_ghr(predict_o_ghr),
    .execute_i_valid(execute_i_valid), .execute_i_pc(execute_i_pc),
    .execute_i_is_branch(execute_i_is_branch), .execute_i_taken(execute_i_taken),
    .execute_i_target(execute_i_target), .execute_i_ghr(execute_i_ghr),
    .execute_i_mispredict(execute_i_mispredict),
    .stat_o_branches(stat_o_branches), .stat_o_mispredicts(stat_o_mispredicts)
  );

  // Reference model
  bit          m_v   [N];
  int          m_tag [N];
  logic [31:0] m_tgt [N];
  bit          m_jmp [N];
  int          m_pht [N];
  int          m_ghr;
  logic [31:0] m_br, m_mp;

  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0; m_pht[i] = 1; m_jmp[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0;
    end
    m_ghr = 0; m_br = '0; m_mp = '0;
  endfunction

  function automatic void predict(input logic [31:0] pc, output bit h, output bit t,
                                  output logic [31:0] tg);
    int i, tt;
    i  = int'((pc >> 2) % N);
    tt = int'((pc >> (IDX_W + 2)) % T);
    h  = m_v[i] && (m_tag[i] == tt);
    t  = h && (m_jmp[i] || (m_pht[i ^ m_ghr] >= 2));
    tg = h ? m_tgt[i] : 32'd0;
  endfunction

  task automatic set_ex(input bit v, input logic [31:0] pc, input bit br, input bit tk,
                        input logic [31:0] tgt, input int gh, input bit mp);
    execute_i_valid      = v;
    execute_i_pc         = pc;
    execute_i_is_branch  = br;
    execute_i_taken      = tk;
    execute_i_target     = tgt;
    execute_i_ghr        = GHR_W'(gh);
    execute_i_mispredict = mp;
  endtask

  task automatic look(input string name);
    bit h, t; logic [31:0] tg;
    @(negedge clk);
    predict(regF_i_pc, h, t, tg);
    chk({name, ".hit"},    32'(predict_o_hit),   32'(h));
    chk({name, ".taken"},  32'(predict_o_taken), 32'(t));
    chk({name, ".target"}, predict_o_target,     tg);
    chk({name, ".ghr"},    32'(predict_o_ghr),   32'(m_ghr));
    chk({name, ".nbr"},    stat_o_branches,      m_br);
    chk({name, ".nmp"},    stat_o_mispredicts,   m_mp);
  endtask

  task automatic tick();
    bit h, t; logic [31:0] tg; int ng, ei, pi, eg;
    predict(regF_i_pc, h, t, tg);
    if (rst) model_reset();
    else begin
      ei = int'((execute_i_pc >> 2) % N);
      eg = int'(execute_i_ghr);
      ng = m_ghr;
      if (execute_i_valid && execute_i_mispredict)
        ng = execute_i_is_branch ? (eg * 2 + int'(execute_i_taken)) % G : eg;
      else if (!ctrl_i_regF_stall && h && !m_jmp[int'((regF_i_pc >> 2) % N)])
        ng = (m_ghr * 2 + int'(t)) % G;
      if (execute_i_valid) begin
        m_br = m_br + 1;
        if (execute_i_mispredict) m_mp = m_mp + 1;
        if (execute_i_is_branch) begin
          pi = ei ^ eg;
          m_pht[pi] = execute_i_taken ? ((m_pht[pi] < 3) ? m_pht[pi] + 1 : 3)
                                      : ((m_pht[pi] > 0) ? m_pht[pi] - 1 : 0);
        end
        if (execute_i_taken) begin
          m_v[ei]   = 1'b1;
          m_tag[ei] = int'((execute_i_pc >> (IDX_W + 2)) % T);
          m_tgt[ei] = execute_i_target;
          m_jmp[ei] = !execute_i_is_branch;
        end
      end
      m_ghr = ng;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_pc();
    return 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 8);
  endfunction

  initial begin
    rst = 1'b1; regF_i_pc = '0; ctrl_i_regF_stall = 1'b0;
    set_ex(0, '0, 0, 0, '0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    regF_i_pc = 32'h8000_0000;
    look("rst");
    chk("rst.hit0", 32'(predict_o_hit), 0);
    chk("rst.taken0", 32'(predict_o_taken), 0);
    chk("rst.target0", predict_o_target, 0);
    chk("rst.ghr0", 32'(predict_o_ghr), 0);
    chk("rst.stats0", stat_o_branches | stat_o_mispredicts, 0);
    tick();

    set_ex(1, 32'h8000_0010, 0, 1, 32'h8000_0100, 0, 1);
    look("jal"); tick();
    set_ex(0, '0, 0, 0, '0, 0, 0);
    regF_i_pc = 32'h8000_0010;
    look("jal_lu");
    chk("jal_lu.hit1", 32'(predict_o_hit), 1);
    chk("jal_lu.taken1", 32'(predict_o_taken), 1);
    chk("jal_lu.tgt", predict_o_target, 32'h8000_0100);
    chk("jal_lu.nbr1", stat_o_branches, 1);
    chk("jal_lu.nmp1", stat_o_mispredicts, 1);
    tick();

    regF_i_pc = 32'h8000_0000;
    for (int k = 0; k < 2; k++) begin
      set_ex(1, 32'h8000_0020, 1, 1, 32'h8000_0200, 0, 0);
      look("trainT"); tick();
    end
    set_ex(0, '0, 0, 0, '0, 0, 0);
    regF_i_pc = 32'h8000_0020;
    look("br_lu");
    chk("br_lu.taken1", 32'(predict_o_taken), 1);
    chk("br_lu.ghr0", 32'(predict_o_ghr), 0);
    tick();
    ctrl_i_regF_stall = 1'b1;
    look("spec");
    chk("spec.ghr1", 32'(predict_o_ghr), 1);
    tick();
    look("stall");
    chk("stall.ghr1", 32'(predict_o_ghr), 1);
    tick();
    ctrl_i_regF_stall = 1'b0;

    regF_i_pc = 32'h8000_0000;
    for (int k = 0; k < 4; k++) begin
      set_ex(1, 32'h8000_0020, 1, 0, 32'h0, 0, k == 3);
      look("trainN"); tick();
    end
    set_ex(0, '0, 0, 0, '0, 0, 0);
    regF_i_pc = 32'h8000_0020;
    ctrl_i_regF_stall = 1'b1;
    look("sat");
    chk("sat.hit1", 32'(predict_o_hit), 1);
    chk("sat.taken0", 32'(predict_o_taken), 0);
    tick();
    set_ex(1, 32'h8000_0020, 1, 1, 32'h8000_0200, 0, 0);
    look("sat_up"); tick();
    set_ex(0, '0, 0, 0, '0, 0, 0);
    look("sat_chk");
    chk("sat_chk.taken0", 32'(predict_o_taken), 0);
    tick();

    ctrl_i_regF_stall = 1'b0;
    set_ex(1, 32'h8000_0040, 1, 0, 32'h0, 5, 1);
    look("rec"); tick();
    set_ex(0, '0, 0, 0, '0, 0, 0);
    ctrl_i_regF_stall = 1'b1;
    look("rec_chk");
    chk("rec_chk.ghr", 32'(predict_o_ghr), 32'h0A);
    tick();

    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      regF_i_pc = rnd_pc();
      ctrl_i_regF_stall = ($urandom_range(0, 3) == 0);
      set_ex($urandom_range(0, 2) != 0, rnd_pc(), $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1, $urandom(), int'($urandom_range(0, G - 1)),
             $urandom_range(0, 2) == 0);
      look("rnd"); tick();
    end
    rst = 1'b0;

    set_ex(1, 32'h8000_0010, 0, 1, 32'h8000_0300, 3, 1);
    regF_i_pc = 32'h8000_0010;
    ctrl_i_regF_stall = 1'b0;
    look("pre_rst"); tick();
    rst = 1'b1;
    set_ex(1, 32'h8000_0020, 1, 1, 32'h8000_0400, 7, 1);
    look("mid_rst"); tick();
    rst = 1'b0;
    set_ex(0, '0, 0, 0, '0, 0, 0);
    look("post_rst");
    chk("post_rst.hit0", 32'(predict_o_hit), 0);
    chk("post_rst.ghr0", 32'(predict_o_ghr), 0);
    chk("post_rst.nbr0", stat_o_branches, 0);
    tick();
    regF_i_pc = 32'h8000_0020;
    look("post_rst2");
    chk("post_rst2.hit0", 32'(predict_o_hit), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter IDX_W, default 6, meaning log2 of PHT/BTB entries (64).
REQ-002 SHALL have parameter TAG_W, default 8, meaning BTB tag width taken from the PC bits directly above the index.
REQ-003 SHALL have parameter GHR_W, default 6, meaning global history length; legal range 1..IDX_W.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port regF_i_pc, input, 32 bits: fetch PC to look up.
REQ-007 SHALL have port ctrl_i_regF_stall, input, 1 bit: fetch stalled; speculative history frozen.
REQ-008 SHALL have port predict_o_taken, output, 1 bit: predicted redirect.
REQ-009 SHALL have port predict_o_target, output, 32 bits: predicted target; 0 when predict_o_hit=0.
REQ-010 SHALL have port predict_o_hit, output, 1 bit: BTB hit.
REQ-011 SHALL have port predict_o_ghr, output, GHR_W bits: current speculative GHR, carried down the pipe.
REQ-012 SHALL have port execute_i_valid, input, 1 bit: a resolved control-transfer instruction is present.
REQ-013 SHALL have port execute_i_pc, input, 32 bits: PC of the resolved instruction.
REQ-014 SHALL have port execute_i_is_branch, input, 1 bit: 1 = conditional branch; 0 = jal/jalr.
REQ-015 SHALL have port execute_i_taken, input, 1 bit: actual direction.
REQ-016 SHALL have port execute_i_target, input, 32 bits: actual target.
REQ-017 SHALL have port execute_i_ghr, input, GHR_W bits: the GHR snapshot taken at prediction time.
REQ-018 SHALL have port execute_i_mispredict, input, 1 bit: the resolution disagrees with the prediction.
REQ-019 SHALL have port stat_o_branches, output, 32 bits: count of resolved instructions.
REQ-020 SHALL have port stat_o_mispredicts, output, 32 bits: count of mispredicts.

Function
REQ-021 Lookup SHALL be combinational in the same cycle as regF_i_pc; BTB index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-022 PHT index SHALL be pc[IDX_W+1:2] XOR the zero-extended GHR; each PHT entry is a 2-bit saturating counter.
REQ-023 predict_o_hit SHALL be asserted when the entry is valid and its tag matches; predict_o_taken = hit AND (entry type is jump OR the PHT counter MSB is 1).
REQ-024 Each BTB entry SHALL hold valid, tag, 32-bit target and a type bit (branch or jump).
REQ-025 Speculative GHR update: when ctrl_i_regF_stall=0 and the lookup hits a branch-type entry, ghr <= {ghr[GHR_W-2:0], predict_o_taken}; when GHR_W=1, ghr <= predict_o_taken.
REQ-026 Recovery: when execute_i_valid and execute_i_mispredict, ghr <= {execute_i_ghr shifted left, execute_i_taken} for a branch, or ghr <= execute_i_ghr for a jump; recovery SHALL override the speculative update in the same cycle.
REQ-027 PHT training: when execute_i_valid and execute_i_is_branch, the counter at (execute_i_pc index XOR execute_i_ghr) SHALL increment if taken, else decrement, saturating at 3 and 0.
REQ-028 BTB write: when execute_i_valid and execute_i_taken, write valid=1, tag, target and type into the entry; a not-taken branch SHALL NOT allocate or modify the BTB.
REQ-029 Same-cycle lookup and update of the same entry SHALL return the pre-update contents; the new value is visible the following cycle.
REQ-030 stat_o_branches SHALL increment on every execute_i_valid; stat_o_mispredicts SHALL increment on execute_i_valid AND execute_i_mispredict; both counters wrap modulo 2^32.
REQ-031 Inputs execute_i_taken, execute_i_mispredict and execute_i_is_branch SHALL be ignored when execute_i_valid=0.

Reset
REQ-032 On rst, on the next rising edge: all BTB valid bits = 0, all PHT counters = 2'b01, ghr = 0, and both stat counters = 0.
REQ-033 rst SHALL dominate any same-cycle update or recovery; after reset, predict_o_hit=0, predict_o_taken=0, predict_o_target=0 and predict_o_ghr=0.
REQ-034 Reset asserted mid-operation SHALL discard all learned state in one cycle.

Verification
REQ-035 Reset, then pc=0x80000000 -> hit=0, taken=0, target=0, ghr=0, both stats=0.
REQ-036 Resolve a jal at 0x80000010 to 0x80000100 (taken, mispredict) -> the next cycle, lookup of 0x80000010 gives hit=1, taken=1, target=0x80000100; stats read 1 and 1.
REQ-037 Train a branch at 0x80000020 taken twice with ghr=0 and GHR_W=1 pinned -> the counter goes 1->2->3; lookup then gives taken=1; four not-taken resolutions saturate the counter at 0.
REQ-038 Branch hit with predicted taken, stall=0 -> ghr shifts in 1; with stall=1 -> ghr is unchanged.
REQ-039 Same-cycle mispredict recovery (execute_i_ghr=6'b000101, taken=0) plus a speculative hit -> ghr=6'b001010.
REQ-040 Run stat_o_branches from 0xFFFFFFFF with one more resolution -> it wraps to 0; rst asserted during training -> all entries invalid the next cycle.
